jt7759_seq: RTL



---
 rtl/jt7759_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/jt7759_seq.sv
`timescale 1ns/1ps
// jt7759_seq -- request sequencer for the jt7759 ADPCM chip.
//
// Queues sample numbers in a small circular FIFO and plays them one at a
// time. Each request is written to the chip with a cs/wrn strobe. The
// sequencer then waits for busyn to fall (playback started) and to rise
// again (playback done) before the next request is issued. A busyn that
// never falls is abandoned after BUSY_TO ticks and flagged on tout.
//
// Handshake: a push is a one-cycle request. It is accepted when the FIFO
// has room, or when it is full and the head is popped in the same cycle.
// Otherwise it is dropped and ovf is set. There is no back-pressure signal.
//
// Ports:
//   rst, clk      asynchronous active-high reset, system clock
//   cen           clock enable tick (same strobe as the chip's cen_ctl)
//   push, snd     request strobe and sample number
//   abort         level input: stop playback, flush the queue, reset the chip
//   busyn, drqn   chip status inputs
//   cs, wrn, din  chip write interface
//   chip_rst      chip reset, active high
//   full, empty   FIFO status
//   level         FIFO occupancy, 0..DEPTH
//   ovf, tout     sticky flags: push dropped, busy timeout
//   dbg_state     FSM state: 0 IDLE, 1 SETUP, 2 STROBE, 3 HOLD, 4 WAITB,
//                 5 PLAY, 6 ABORT
module jt7759_seq #(
  parameter int DEPTH   = 4,
  parameter int PULSE   = 4,
  parameter int BUSY_TO = 32
) (
  input  logic                     rst,
  input  logic                     clk,
  input  logic                     cen,
  input  logic                     push,
  input  logic [7:0]               snd,
  input  logic                     abort,
  input  logic                     busyn,
  input  logic                     drqn,
  output logic                     cs,
  output logic                     wrn,
  output logic [7:0]               din,
  output logic                     chip_rst,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     tout,
  output logic [2:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] PULSE_LAST = 8'(PULSE - 1);
  localparam logic [7:0] BUSY_LAST  = 8'(BUSY_TO - 1);
  // ABORT lasts for the abort pulse plus two cycles after abort drops.
  localparam logic [7:0] ABORT_LAST = 8'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_WAITB  = 3'd4,
    S_PLAY   = 3'd5,
    S_ABORT  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [7:0]      din_q, din_d;
  logic            ovf_q, ovf_d;
  logic            tout_q, tout_d;
  logic            rst_hold_q, rst_hold_d;
  logic            pop;
  logic            tout_set;
  logic            wr_en;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign level     = level_q;
  assign din       = din_q;
  assign ovf       = ovf_q;
  assign tout      = tout_q;
  assign dbg_state = state_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      din_q      <= '0;
      ovf_q      <= 1'b0;
      tout_q     <= 1'b0;
      rst_hold_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      din_q      <= din_d;
      ovf_q      <= ovf_d;
      tout_q     <= tout_d;
      rst_hold_q <= rst_hold_d;
      mem_q      <= mem_d;
    end
  end

  // Next state. abort wins over everything and is not cen-qualified, and
  // neither is the ABORT countdown. Every other transition waits for a tick.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    tout_set = 1'b0;
    if (abort) begin
      state_d = S_ABORT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // empty is from the registered level, so a push that lands in
          // this same cycle cannot be popped until the next one.
          if (cen && !empty && busyn && drqn) begin
            state_d = S_SETUP;
            pop     = 1'b1;
          end
        end
        S_SETUP: begin
          if (cen) begin
            state_d = S_STROBE;
            cnt_d   = '0;
          end
        end
        S_STROBE: begin
          if (cen) begin
            if (cnt_q == PULSE_LAST) begin
              state_d = S_HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_HOLD: begin
          if (cen) begin
            state_d = S_WAITB;
            cnt_d   = '0;
          end
        end
        S_WAITB: begin
          if (cen) begin
            if (!busyn) begin
              state_d = S_PLAY;
              cnt_d   = '0;
            end else if (cnt_q == BUSY_LAST) begin
              state_d  = S_IDLE;
              cnt_d    = '0;
              tout_set = 1'b1;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_PLAY: begin
          if (cen && busyn) state_d = S_IDLE;
        end
        S_ABORT: begin
          if (cnt_q == ABORT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FIFO, data latch and sticky flags.
  always_comb begin
    mem_d      = mem_q;
    rst_hold_d = 1'b0;
    // A full FIFO can still take a push when the head leaves this cycle.
    wr_en      = push && !abort && (!full || pop);
    din_d      = pop ? mem_q[rd_ptr_q] : din_q;
    if (wr_en) mem_d[wr_ptr_q] = snd;
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      tout_d   = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LW'(wr_en) - LW'(pop);
      ovf_d    = ovf_q | (push && !wr_en);
      tout_d   = tout_q | tout_set;
    end
  end

  // Chip-facing outputs decode straight from the state register, so an
  // asynchronous reset forces wrn high at once with no low glitch.
  always_comb begin
    cs       = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
    wrn      = (state_q != S_STROBE);
    chip_rst = rst_hold_q || (state_q == S_ABORT);
  end

endmodule
